// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcodes,
// ALU operation codes and datapath mux-select values.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_INIT    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_EXEC_R  = 4'd3,
      S_EXEC_I  = 4'd4,
      S_WB_ALU  = 4'd5,
      S_MEM_RD  = 4'd6,
      S_WB_MEM  = 4'd7,
      S_MEM_WR  = 4'd8,
      S_WB_LI   = 4'd9,
      S_BRANCH  = 4'd10,
      S_JUMP    = 4'd11,
      S_HALT    = 4'd12,
      S_ILLEGAL = 4'd13
   } state_t;

   localparam logic [5:0] OP_LD   = 6'b100000;
   localparam logic [5:0] OP_ST   = 6'b100001;
   localparam logic [5:0] OP_LI   = 6'b100010;
   localparam logic [5:0] OP_BNE  = 6'b100011;
   localparam logic [5:0] OP_J    = 6'b100100;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   localparam logic       SRCA_PC   = 1'b0;
   localparam logic       SRCA_REG  = 1'b1;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_SEXT = 2'b10;
   localparam logic [1:0] SRCB_ZEXT = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] MTR_ALUOUT = 2'b00;
   localparam logic [1:0] MTR_MDR    = 2'b01;
   localparam logic [1:0] MTR_IMM    = 2'b10;

   // State entered after DECODE for a given opcode.
   function automatic state_t dispatch(input logic [5:0] op);
      if (op[5:4] == 2'b00) return S_EXEC_R;
      if (op[5:4] == 2'b01) return S_EXEC_I;
      case (op)
         OP_LD:   return S_MEM_RD;
         OP_ST:   return S_MEM_WR;
         OP_LI:   return S_WB_LI;
         OP_BNE:  return S_BRANCH;
         OP_J:    return S_JUMP;
         OP_HALT: return S_HALT;
         default: return S_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the current state (plus the ALU function field
// captured in DECODE) onto every datapath control.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [3:0] op_func,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [3:0] ALUOp,
   output logic       halted,
   output logic       illegal
);

   // Per-state control values; anything not listed for a state stays 0.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = SRCA_PC;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = MTR_ALUOUT;
      ALUSrcB     = SRCB_B;
      PCSource    = PCSRC_ALU;
      ALUOp       = ALU_ADD;
      halted      = 1'b0;
      illegal     = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead  = 1'b1;
            IRWrite  = 1'b1;
            ALUSrcB  = SRCB_ONE;
            PCWrite  = 1'b1;
         end
         S_DECODE: ALUSrcB = SRCB_SEXT;
         S_EXEC_R: begin
            ALUSrcA = SRCA_REG;
            RegDst  = 1'b1;
            ALUOp   = op_func;
         end
         S_EXEC_I: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_SEXT;
            ALUOp   = op_func;
         end
         S_MEM_RD: MemRead  = 1'b1;
         S_MEM_WR: MemWrite = 1'b1;
         S_WB_ALU: RegWrite = 1'b1;
         S_WB_MEM: begin
            RegWrite = 1'b1;
            MemtoReg = MTR_MDR;
         end
         S_WB_LI: begin
            RegWrite = 1'b1;
            MemtoReg = MTR_IMM;
         end
         S_BRANCH: begin
            ALUSrcA     = SRCA_REG;
            RegDst      = 1'b1;
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         S_HALT:    halted  = 1'b1;
         S_ILLEGAL: illegal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: state register and next-state logic; outputs
// come from mc_ctrl_decode. Optional MC_INSTR_COUNT_EN adds a 16-bit
// retired-instruction counter port.
module multicycle_controller
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [3:0] ALUOp,
   output logic       halted,
   output logic       illegal,
   output logic [3:0] state
`ifdef MC_INSTR_COUNT_EN
   ,
   output logic [15:0] instr_count
`endif
);

   state_t     cur;
   logic       run;
   logic [3:0] op_func;

   assign state = cur;

   // State register; run delays the INIT->FETCH step by one edge after reset
   // release, and the ALU function field is captured only in DECODE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur     <= S_INIT;
         run     <= 1'b0;
         op_func <= '0;
      end else begin
         run <= 1'b1;
         case (cur)
            S_INIT:   if (run) cur <= S_FETCH;
            S_FETCH:  cur <= S_DECODE;
            S_DECODE: begin
               cur     <= dispatch(opcode);
               op_func <= opcode[3:0];
            end
            S_EXEC_R, S_EXEC_I: cur <= S_WB_ALU;
            S_MEM_RD: cur <= S_WB_MEM;
            S_WB_ALU, S_WB_MEM, S_MEM_WR, S_WB_LI, S_BRANCH, S_JUMP:
               cur <= S_FETCH;
            S_HALT, S_ILLEGAL: cur <= cur;
            default:  cur <= S_INIT;
         endcase
      end
   end

`ifdef MC_INSTR_COUNT_EN
   // Counts every return to FETCH from an instruction's final state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         instr_count <= '0;
      else if (cur inside {S_WB_ALU, S_WB_MEM, S_MEM_WR, S_WB_LI, S_BRANCH, S_JUMP})
         instr_count <= instr_count + 16'd1;
   end
`endif

   mc_ctrl_decode u_decode (
      .state       (cur),
      .op_func     (op_func),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .ALUSrcA     (ALUSrcA),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .MemtoReg    (MemtoReg),
      .ALUSrcB     (ALUSrcB),
      .PCSource    (PCSource),
      .ALUOp       (ALUOp),
      .halted      (halted),
      .illegal     (illegal)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller. Each instruction
// is expanded into its expected state-code sequence and per-cycle controls.
module tb_multicycle_controller;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic       PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite, RegDst;
   logic [1:0] MemtoReg, ALUSrcB, PCSource;
   logic [3:0] ALUOp;
   logic       halted, illegal;
   logic [3:0] state;
`ifdef MC_INSTR_COUNT_EN
   logic [15:0] instr_count;
`endif

   multicycle_controller dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .ALUSrcA     (ALUSrcA),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .MemtoReg    (MemtoReg),
      .ALUSrcB     (ALUSrcB),
      .PCSource    (PCSource),
      .ALUOp       (ALUOp),
      .halted      (halted),
      .illegal     (illegal),
      .state       (state)
`ifdef MC_INSTR_COUNT_EN
      ,
      .instr_count (instr_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [19:0] obs;
   assign obs = {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite, RegDst,
                 MemtoReg, ALUSrcB, PCSource, ALUOp, halted, illegal};

   int n_checks = 0;
   int n_pass   = 0;
   int cnt      = 0;
   int seq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Expected control vector for a state code, straight from the per-state tables.
   function automatic logic [19:0] exp_ctrl(input int s, input logic [5:0] op);
      logic pcw, pcwc, mr, mw, irw, srca, rw, rd, h, il;
      logic [1:0] mtr, srcb, pcs;
      logic [3:0] aop;
      {pcw, pcwc, mr, mw, irw, srca, rw, rd, h, il} = '0;
      {mtr, srcb, pcs, aop} = '0;
      case (s)
         1:  begin mr = 1; irw = 1; srcb = 2'b01; pcw = 1; end
         2:  srcb = 2'b10;
         3:  begin srca = 1; rd = 1; aop = op[3:0]; end
         4:  begin srca = 1; srcb = 2'b10; aop = op[3:0]; end
         5:  rw = 1;
         6:  mr = 1;
         7:  begin rw = 1; mtr = 2'b01; end
         8:  mw = 1;
         9:  begin rw = 1; mtr = 2'b10; end
         10: begin srca = 1; rd = 1; aop = 4'b0001; pcwc = 1; pcs = 2'b01; end
         11: begin pcw = 1; pcs = 2'b10; end
         12: h = 1;
         13: il = 1;
         default: ;
      endcase
      return {pcw, pcwc, mr, mw, irw, srca, rw, rd, mtr, srcb, pcs, aop, h, il};
   endfunction

   // Expected state-code walk of one instruction, FETCH first.
   function automatic void build_seq(input logic [5:0] op);
      seq = {1, 2};
      if (op[5:4] == 2'b00)      seq.push_back(3);
      else if (op[5:4] == 2'b01) seq.push_back(4);
      else if (op == 6'b100000)  seq.push_back(6);
      else if (op == 6'b100001)  seq.push_back(8);
      else if (op == 6'b100010)  seq.push_back(9);
      else if (op == 6'b100011)  seq.push_back(10);
      else if (op == 6'b100100)  seq.push_back(11);
      else if (op == 6'b111111)  seq.push_back(12);
      else                       seq.push_back(13);
      if (op[5] == 1'b0)         seq.push_back(5);
      else if (op == 6'b100000)  seq.push_back(7);
   endfunction

   task automatic check_cycle(input int s, input logic [5:0] op);
      check($sformatf("state@%0d", s), 32'(state), 32'(s));
      check($sformatf("ctrl@%0d", s), 32'(obs), 32'(exp_ctrl(s, op)));
`ifdef MC_INSTR_COUNT_EN
      if (s == 1) check("instr_count", 32'(instr_count), 32'(cnt[15:0]));
`endif
   endtask

   // Assert reset between edges, check immediate clear, release, walk INIT.
   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_ctrl", 32'(obs), 32'd0);
`ifdef MC_INSTR_COUNT_EN
      check("rst_count", 32'(instr_count), 32'd0);
`endif
      @(negedge clk);
      check("rst_hold", 32'(state), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("init_cycle", 32'(state), 32'd0);
      check("init_ctrl", 32'(obs), 32'd0);
      cnt = 0;
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [5:0] op, input int abort_at);
      int last;
      build_seq(op);
      for (int k = 0; k < seq.size(); k++) begin
         check_cycle(seq[k], op);
         if (k == abort_at) begin
            do_reset();
            return;
         end
         opcode = (seq[k] == 2) ? op : 6'($urandom);
         @(negedge clk);
      end
      last = seq[seq.size()-1];
      if (last == 12 || last == 13) begin
         repeat (4) begin
            check_cycle(last, op);
            opcode = 6'($urandom);
            @(negedge clk);
         end
         do_reset();
      end else begin
         cnt++;
      end
   endtask

   function automatic logic [5:0] pick_op();
      int r;
      r = $urandom_range(0, 99);
      if (r < 25) return {2'b00, 4'($urandom)};
      if (r < 45) return {2'b01, 4'($urandom)};
      if (r < 55) return 6'b100000;
      if (r < 65) return 6'b100001;
      if (r < 72) return 6'b100010;
      if (r < 80) return 6'b100011;
      if (r < 88) return 6'b100100;
      if (r < 93) return 6'b111111;
      return 6'($urandom_range(37, 62));
   endfunction

   initial begin
      logic [5:0] op;
      int ab;
      reset  = 1'b0;
      opcode = '0;
      @(negedge clk);
      do_reset();
      // directed: R-op 000101, LD then ST, BNE, J, reset in MEM_WR
      run_instr(6'b000101, -1);
      run_instr(6'b100000, -1);
      run_instr(6'b100001, -1);
      run_instr(6'b100011, -1);
      run_instr(6'b100100, -1);
      run_instr(6'b100001, 2);
      run_instr(6'b101010, -1);
      run_instr(6'b111111, -1);
      for (int i = 0; i < 400; i++) begin
         op = pick_op();
         ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1;
         run_instr(op, ab);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
